uart: RTL and testbench

Memory-mapped 8N1 UART peripheral in I/O select slot 0 of the data bus (`data_addr_i[13]=1`, `data_addr_i[8:6]=3'b000`). It uses the same register-port convention as the timer, GPIO and I2C peripherals: write strobe, byte enables, 6-bit register offset, 32-bit write data, and combinational read data. The bus registers the read data into `data_rdata_o`. The block contains a programmable baud generator, a 4-entry TX FIFO and a 4-entry RX FIFO, and connects to the chip-level `tx_o`/`rx_i` pins.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/sync_fifo.sv | 51 +++++
 rtl/uart.sv | 279 +++++++++++++++++++++++++++
 tb/tb_uart.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the memory-mapped 8N1 UART: register offsets,
// CTRL/STATUS bit positions and the state encoding used by both serial FSMs.
package uart_pkg;

    localparam logic [5:0] UART_CTRL   = 6'h00;
    localparam logic [5:0] UART_STATUS = 6'h04;
    localparam logic [5:0] UART_TXDATA = 6'h08;
    localparam logic [5:0] UART_RXDATA = 6'h0C;

    localparam int CTRL_TX_EN = 16;
    localparam int CTRL_RX_EN = 17;

    localparam int ST_TX_COUNT    = 0;
    localparam int ST_TX_FULL     = 3;
    localparam int ST_TX_EMPTY    = 4;
    localparam int ST_RX_COUNT    = 5;
    localparam int ST_RX_FULL     = 8;
    localparam int ST_RX_EMPTY    = 9;
    localparam int ST_TX_BUSY     = 10;
    localparam int ST_RX_OVERRUN  = 11;
    localparam int ST_FRAME_ERR   = 12;
    localparam int ST_TX_OVERFLOW = 13;

    localparam logic [15:0] MIN_DIV = 16'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

    // Divisors below the minimum cannot fit a half-bit wait, so they are raised.
    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count; head word reads 0 when empty.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart.sv
// Memory-mapped 8N1 UART: CTRL/STATUS/TXDATA/RXDATA registers, programmable
// baud divisor, TX and RX FIFOs, registered tx_o and synchronized rx_i.
module uart
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] RESET_DIV  = 16'd868
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [5:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic        rx_i,
    output logic        tx_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [5:0]  word_addr;
    logic        wr_ctrl, wr_status, wr_txdata, wr_rxdata;
    logic [15:0] div;
    logic [15:0] new_div;
    logic        tx_en, rx_en;
    logic        rx_overrun, frame_err, tx_overflow;

    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]    tx_head;
    logic [CW-1:0] tx_count;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]    rx_head;
    logic [CW-1:0] rx_count;

    uart_state_e tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_idx;
    logic [7:0]  tx_shift;
    logic        tx_tick;

    uart_state_e rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_idx;
    logic [7:0]  rx_shift;
    logic [1:0]  rx_sync;
    logic        rx_s, rx_prev, rx_tick;
    logic        rx_done, rx_good, rx_bad;

    logic [31:0] status;
    logic        unused;

    assign unused = ^{wdata_i[31:18], addr_i[1:0], be_i[3]};

    // ---------------- register decode ----------------
    assign word_addr = {addr_i[5:2], 2'b00};
    assign wr_ctrl   = we_i && (word_addr == UART_CTRL);
    assign wr_status = we_i && (word_addr == UART_STATUS);
    assign wr_txdata = we_i && (word_addr == UART_TXDATA) && be_i[0];
    assign wr_rxdata = we_i && (word_addr == UART_RXDATA) && be_i[0];

    assign new_div = {be_i[1] ? wdata_i[15:8] : div[15:8],
                      be_i[0] ? wdata_i[7:0]  : div[7:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div   <= RESET_DIV;
            tx_en <= 1'b0;
            rx_en <= 1'b0;
        end else if (wr_ctrl) begin
            if (be_i[0] || be_i[1]) div <= clamp_div(new_div);
            if (be_i[2]) begin
                tx_en <= wdata_i[CTRL_TX_EN];
                rx_en <= wdata_i[CTRL_RX_EN];
            end
        end
    end

    // Sticky flags: a new event in the same cycle as a clear wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_overrun  <= 1'b0;
            frame_err   <= 1'b0;
            tx_overflow <= 1'b0;
        end else begin
            if (wr_status && be_i[1] && wdata_i[ST_RX_OVERRUN])  rx_overrun  <= 1'b0;
            if (wr_status && be_i[1] && wdata_i[ST_FRAME_ERR])   frame_err   <= 1'b0;
            if (wr_status && be_i[1] && wdata_i[ST_TX_OVERFLOW]) tx_overflow <= 1'b0;
            if (rx_done && rx_good && rx_full && !rx_pop) rx_overrun  <= 1'b1;
            if (rx_bad)                                   frame_err   <= 1'b1;
            if (wr_txdata && tx_full)                     tx_overflow <= 1'b1;
        end
    end

    // ---------------- FIFOs ----------------
    assign tx_push = wr_txdata & ~tx_full;
    assign rx_pop  = wr_rxdata;
    assign rx_push = rx_done & rx_good;

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (wdata_i[7:0]),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (rx_shift),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // ---------------- TX FSM ----------------
    // The next frame starts straight out of the stop bit, so there is no idle gap.
    assign tx_tick = (tx_cnt == 16'd0);
    assign tx_pop  = tx_en & ~tx_empty &
                     ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_tick));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state <= S_IDLE;
            tx_o     <= 1'b1;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    if (tx_pop) begin
                        tx_state <= S_START;
                        tx_o     <= 1'b0;
                        tx_cnt   <= div - 16'd1;
                        tx_shift <= tx_head;
                    end
                end
                S_START: begin
                    if (tx_tick) begin
                        tx_state <= S_DATA;
                        tx_o     <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_idx   <= '0;
                        tx_cnt   <= div - 16'd1;
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (tx_tick) begin
                        tx_cnt <= div - 16'd1;
                        if (tx_idx == 3'd7) begin
                            tx_state <= S_STOP;
                            tx_o     <= 1'b1;
                        end else begin
                            tx_o     <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_idx   <= tx_idx + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                default: begin
                    if (tx_tick) begin
                        if (tx_pop) begin
                            tx_state <= S_START;
                            tx_o     <= 1'b0;
                            tx_cnt   <= div - 16'd1;
                            tx_shift <= tx_head;
                        end else begin
                            tx_state <= S_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    // ---------------- RX path ----------------
    assign rx_s    = rx_sync[1];
    assign rx_tick = (rx_cnt == 16'd0);
    assign rx_done = rx_en && (rx_state == S_STOP) && rx_tick;
    assign rx_good = rx_s;
    assign rx_bad  = rx_done && !rx_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], rx_i};
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else if (!rx_en) begin
            rx_state <= S_IDLE;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_state <= S_START;
                        rx_cnt   <= (div >> 1) - 16'd1;
                    end
                end
                S_START: begin
                    if (rx_tick) begin
                        if (rx_s) begin
                            rx_state <= S_IDLE;
                        end else begin
                            rx_state <= S_DATA;
                            rx_idx   <= '0;
                            rx_cnt   <= div - 16'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (rx_tick) begin
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        rx_cnt   <= div - 16'd1;
                        if (rx_idx == 3'd7) rx_state <= S_STOP;
                        else                rx_idx   <= rx_idx + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                default: begin
                    if (rx_tick) rx_state <= S_IDLE;
                    else         rx_cnt   <= rx_cnt - 16'd1;
                end
            endcase
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        status = '0;
        status[ST_TX_COUNT +: 3] = 3'(tx_count);
        status[ST_TX_FULL]       = tx_full;
        status[ST_TX_EMPTY]      = tx_empty;
        status[ST_RX_COUNT +: 3] = 3'(rx_count);
        status[ST_RX_FULL]       = rx_full;
        status[ST_RX_EMPTY]      = rx_empty;
        status[ST_TX_BUSY]       = (tx_state != S_IDLE);
        status[ST_RX_OVERRUN]    = rx_overrun;
        status[ST_FRAME_ERR]     = frame_err;
        status[ST_TX_OVERFLOW]   = tx_overflow;
    end

    always_comb begin
        rdata_o = '0;
        case (word_addr)
            UART_CTRL:   rdata_o = {14'd0, rx_en, tx_en, div};
            UART_STATUS: rdata_o = status;
            UART_RXDATA: rdata_o = {23'd0, ~rx_empty, rx_head};
            default:     rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_uart.sv
// Directed bench for the UART: register access, TX framing, FIFO limits,
// loopback receive, RX error flags, glitch rejection and mid-frame reset.
module tb_uart;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = 4'h0;
    logic [5:0]  addr_i = 6'h0;
    logic [31:0] wdata_i = 32'h0;
    logic [31:0] rdata_o;
    logic        rx_i;
    logic        tx_o;
    logic        loop_en = 1'b0;
    logic        rx_drv = 1'b1;

    int checks = 0;
    int errors = 0;

    assign rx_i = loop_en ? tx_o : rx_drv;

    always #5 clk_i = ~clk_i;

    uart dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (we_i),
        .be_i    (be_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o),
        .rx_i    (rx_i),
        .tx_o    (tx_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [5:0] a, input logic [31:0] exp);
        addr_i = a;
        #1;
        chk(tag, rdata_o, exp);
    endtask

    task automatic wr(input logic [5:0] a, input logic [3:0] be, input logic [31:0] d);
        @(negedge clk_i);
        addr_i  = a;
        be_i    = be;
        wdata_i = d;
        we_i    = 1'b1;
        @(posedge clk_i);
        #1;
        we_i = 1'b0;
        be_i = 4'h0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_b, input int div);
        logic [9:0] f;
        f = {stop_b, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            rx_drv = f[i];
            repeat (div - 1) @(negedge clk_i);
        end
        @(negedge clk_i);
        rx_drv = 1'b1;
    endtask

    initial begin
        logic [9:0] pat;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        // reset state
        chk("reset_tx_o", {31'd0, tx_o}, 32'd1);
        chk_reg("reset_ctrl", 6'h00, 32'h0000_0364);
        chk_reg("reset_status", 6'h04, 32'h0000_0210);
        chk_reg("reset_rxdata", 6'h0C, 32'h0000_0000);

        // divisor clamp, then div=8 with tx_en
        wr(6'h00, 4'b0011, 32'h0000_0002);
        chk_reg("div_clamp", 6'h00, 32'h0000_0004);
        wr(6'h00, 4'b1111, 32'h0001_0008);
        chk_reg("ctrl_div8_txen", 6'h00, 32'h0001_0008);

        // TX frame 0x55: start, LSB first data, stop
        pat = 10'b1_0101_0101_0;
        wr(6'h08, 4'b0001, 32'h0000_0055);
        @(posedge clk_i);
        #1;
        chk("tx_start_edge", {31'd0, tx_o}, 32'd0);
        for (int b = 0; b < 10; b++) begin
            repeat ((b == 0) ? 4 : 8) @(posedge clk_i);
            #1;
            chk($sformatf("tx_bit%0d", b), {31'd0, tx_o}, {31'd0, pat[b]});
        end
        repeat (3) @(posedge clk_i);
        #1;
        chk_reg("tx_busy_last", 6'h04, 32'h0000_0610);
        @(posedge clk_i);
        #1;
        chk_reg("tx_busy_fall", 6'h04, 32'h0000_0210);

        // TX overflow with tx_en=0, then four back-to-back frames
        wr(6'h00, 4'b0100, 32'h0000_0000);
        for (int i = 0; i < 5; i++) wr(6'h08, 4'b0001, 32'h0000_0030 + i);
        chk_reg("tx_overflow", 6'h04, 32'h0000_220C);
        wr(6'h00, 4'b0100, 32'h0001_0000);
        @(posedge clk_i);
        repeat (319) @(posedge clk_i);
        #1;
        chk_reg("tx_4frames_busy", 6'h04, 32'h0000_2610);
        @(posedge clk_i);
        #1;
        chk_reg("tx_4frames_done", 6'h04, 32'h0000_2210);
        wr(6'h04, 4'b0010, 32'h0000_2000);
        chk_reg("tx_overflow_w1c", 6'h04, 32'h0000_0210);

        // RX loopback of 0xA3
        loop_en = 1'b1;
        wr(6'h00, 4'b0100, 32'h0003_0000);
        wr(6'h08, 4'b0001, 32'h0000_00A3);
        repeat (100) @(posedge clk_i);
        #1;
        chk_reg("loop_status", 6'h04, 32'h0000_0030);
        chk_reg("loop_rxdata", 6'h0C, 32'h0000_01A3);
        wr(6'h0C, 4'b0001, 32'h0000_0000);
        chk_reg("loop_pop", 6'h04, 32'h0000_0210);
        loop_en = 1'b0;

        // frame error: stop bit driven low
        send_rx(8'h5A, 1'b0, 8);
        repeat (20) @(posedge clk_i);
        #1;
        chk_reg("frame_err", 6'h04, 32'h0000_1210);

        // overrun: five frames into a four-entry FIFO
        for (int i = 0; i < 5; i++) send_rx(8'h11 + 8'(i), 1'b1, 8);
        repeat (20) @(posedge clk_i);
        #1;
        chk_reg("overrun_status", 6'h04, 32'h0000_1990);
        chk_reg("overrun_head", 6'h0C, 32'h0000_0111);
        wr(6'h04, 4'b0010, 32'h0000_1800);
        chk_reg("w1c_clear", 6'h04, 32'h0000_0190);
        wr(6'h0C, 4'b0001, 32'h0000_0000);
        chk_reg("pop_head2", 6'h0C, 32'h0000_0112);
        chk_reg("pop_count3", 6'h04, 32'h0000_0070);
        for (int i = 0; i < 4; i++) wr(6'h0C, 4'b0001, 32'h0000_0000);
        chk_reg("pop_drained", 6'h04, 32'h0000_0210);

        // glitch rejection at div=16
        wr(6'h00, 4'b0011, 32'h0000_0010);
        chk_reg("ctrl_div16", 6'h00, 32'h0003_0010);
        @(negedge clk_i);
        rx_drv = 1'b0;
        repeat (2) @(negedge clk_i);
        rx_drv = 1'b1;
        repeat (40) @(posedge clk_i);
        #1;
        chk_reg("glitch_no_push", 6'h04, 32'h0000_0210);

        // reset in the middle of a TX frame
        wr(6'h08, 4'b0001, 32'h0000_0000);
        repeat (30) @(posedge clk_i);
        #1;
        chk("midframe_tx_low", {31'd0, tx_o}, 32'd0);
        chk_reg("midframe_busy", 6'h04, 32'h0000_0610);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_tx_o", {31'd0, tx_o}, 32'd1);
        chk_reg("rst_status", 6'h04, 32'h0000_0210);
        chk_reg("rst_ctrl", 6'h00, 32'h0000_0364);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        chk("post_rst_tx_o", {31'd0, tx_o}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
